// File: rtl/i2s_pkg.sv
// ============================================================================
// Module   : i2s_pkg
// Brief    : Shared I2S frame constants and types for the i2s_tx / i2s_rx pair.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2s_pkg;

    localparam int FRAME_BCLKS = 64;
    localparam int SLOT_BCLKS  = 32;
    localparam int CNT_W       = $clog2(FRAME_BCLKS);

    typedef logic [CNT_W-1:0] bit_cnt_t;
    typedef logic [CNT_W-2:0] slot_pos_t;

    localparam bit_cnt_t CNT_LAST = bit_cnt_t'(FRAME_BCLKS - 1);

    // What happens to the shift words at the frame boundary.
    typedef enum logic [1:0] {
        XFER_NONE   = 2'd0,
        XFER_HOLD   = 2'd1,
        XFER_BYPASS = 2'd2,
        XFER_REPEAT = 2'd3
    } xfer_t;

    function automatic slot_pos_t slot_pos(input bit_cnt_t cnt);
        return cnt[CNT_W-2:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_slot_shifter.sv
// ============================================================================
// Module   : i2s_slot_shifter
// Brief    : One channel word: parallel load, reload of last word, MSB-first shift.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_slot_shifter #(
    parameter int BITSIZE = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               reload,
    input  logic               shift,
    input  logic [BITSIZE-1:0] din,
    output logic               msb
);

    // word keeps the last loaded sample so an underrun can resend it.
    logic [BITSIZE-1:0] word;
    logic [BITSIZE-1:0] sreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word <= '0;
            sreg <= '0;
        end else if (load) begin
            word <= din;
            sreg <= din;
        end else if (reload) begin
            sreg <= word;
        end else if (shift) begin
            sreg <= {sreg[BITSIZE-2:0], 1'b0};
        end
    end

    assign msb = sreg[BITSIZE-1];

endmodule

`default_nettype wire

// File: rtl/i2s_tx.sv
// ============================================================================
// Module   : i2s_tx
// Brief    : I2S transmitter, 64 bclk frame, holding register with bypass/repeat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_tx
    import i2s_pkg::*;
#(
    parameter int BITSIZE = 16
) (
    input  logic               bclk,
    input  logic               reset,
    input  logic [BITSIZE-1:0] left_in,
    input  logic [BITSIZE-1:0] right_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               clear_underrun,
    output logic               lrclk,
    output logic               sdata,
    output logic               frame_start,
    output logic               underrun
);

    localparam slot_pos_t LAST_J = slot_pos_t'(BITSIZE);

    bit_cnt_t           bit_cnt;
    bit_cnt_t           next_cnt;
    logic               run;
    logic               hold_full;
    logic [BITSIZE-1:0] hold_left;
    logic [BITSIZE-1:0] hold_right;

    xfer_t              xfer;
    slot_pos_t          next_j;
    logic               next_slot;
    logic               data_pos;
    logic               accept;
    logic               load;
    logic               reload;
    logic               msb_left;
    logic               msb_right;
    logic [BITSIZE-1:0] load_left;
    logic [BITSIZE-1:0] load_right;

    assign in_ready = ~hold_full;
    assign accept   = in_valid & in_ready;

    // Outputs are registered from the next count so they line up with bit_cnt.
    // The first edge after reset release holds the count at 0 to open a frame.
    always_comb begin
        next_cnt   = run ? bit_cnt + bit_cnt_t'(1) : '0;
        next_j     = slot_pos(next_cnt);
        next_slot  = next_cnt[CNT_W-1];
        data_pos   = (next_j != '0) && (next_j <= LAST_J);
        xfer       = XFER_NONE;
        if (run && (bit_cnt == CNT_LAST)) begin
            if (hold_full) begin
                xfer = XFER_HOLD;
            end else if (accept) begin
                xfer = XFER_BYPASS;
            end else begin
                xfer = XFER_REPEAT;
            end
        end
        load       = (xfer == XFER_HOLD) || (xfer == XFER_BYPASS);
        reload     = (xfer == XFER_REPEAT);
        load_left  = hold_full ? hold_left  : left_in;
        load_right = hold_full ? hold_right : right_in;
    end

    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            run         <= 1'b0;
            lrclk       <= 1'b0;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
            hold_full   <= 1'b0;
            hold_left   <= '0;
            hold_right  <= '0;
            underrun    <= 1'b0;
        end else begin
            run         <= 1'b1;
            bit_cnt     <= next_cnt;
            lrclk       <= next_slot;
            frame_start <= (next_cnt == '0);
            sdata       <= data_pos & (next_slot ? msb_right : msb_left);

            if (xfer == XFER_HOLD) begin
                hold_full <= 1'b0;
            end else if (accept && (xfer != XFER_BYPASS)) begin
                hold_full  <= 1'b1;
                hold_left  <= left_in;
                hold_right <= right_in;
            end

            if (xfer == XFER_REPEAT) begin
                underrun <= 1'b1;
            end else if (clear_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

    i2s_slot_shifter #(.BITSIZE(BITSIZE)) u_left (
        .clk    (bclk),
        .reset  (reset),
        .load   (load),
        .reload (reload),
        .shift  (data_pos & ~next_slot),
        .din    (load_left),
        .msb    (msb_left)
    );

    i2s_slot_shifter #(.BITSIZE(BITSIZE)) u_right (
        .clk    (bclk),
        .reset  (reset),
        .load   (load),
        .reload (reload),
        .shift  (data_pos & next_slot),
        .din    (load_right),
        .msb    (msb_right)
    );

endmodule

`default_nettype wire
